opti_booth_mult_p: RTL and testbench

//  Parametrised, fully pipelined radix-4 Booth signed multiplier for the IIR datapath; successor to fixed Q2.14 multiplier.

---
 rtl/opti_mult_pkg.sv | 66 ++++++
 rtl/opti_booth_row.sv | 41 ++++
 rtl/opti_booth_mult_p.sv | 123 ++++++++++++
 tb/tb_opti_booth_mult_p.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/opti_mult_pkg.sv
// Shared definitions for the Booth multiplier and future MAC blocks:
// Booth digit codes, row-count helper and the round/saturate function.
// Build option OPTI_MULT_RNE_EN: when defined, exact ties round to an even
// result LSB; otherwise ties round half up (toward +inf).
package opti_mult_pkg;

  // Booth radix-4 digit encodings
  localparam logic [2:0] B_ZERO = 3'd0;
  localparam logic [2:0] B_P1   = 3'd1;
  localparam logic [2:0] B_P2   = 3'd2;
  localparam logic [2:0] B_M1   = 3'd3;
  localparam logic [2:0] B_M2   = 3'd4;

  // Working width for the shared rounding function; callers sign-extend into it
  localparam int MAX_W = 64;

  typedef struct packed {
    logic                    sat;
    logic signed [MAX_W-1:0] p;
  } sat_res_t;

  // Number of radix-4 Booth rows for a w-bit recoded operand
  function automatic int booth_rows(input int w);
    return w / 2;
  endfunction

  // Round the exact product down by 'shift' bits, then clip to out_w signed bits
  function automatic sat_res_t sat_round(input logic signed [MAX_W-1:0] full,
                                         input int shift, input int out_w);
    logic signed [MAX_W-1:0] one;
    logic signed [MAX_W-1:0] half;
    logic signed [MAX_W-1:0] mask;
    logic signed [MAX_W-1:0] r;
    logic signed [MAX_W-1:0] q;
    logic signed [MAX_W-1:0] max_v;
    logic signed [MAX_W-1:0] min_v;
    sat_res_t res;
    res   = '0;
    one   = {{(MAX_W-1){1'b0}}, 1'b1};
    half  = one << (shift - 1);
    mask  = (half << 1) - one;
    r     = full + half;
    q     = r >>> shift;
`ifdef OPTI_MULT_RNE_EN
    // Exact tie already rounded up; step back if that produced an odd LSB
    if (((full & mask) == half) && q[0]) q = q - one;
`else
    // Round half up needs no tie handling; mask only matters for RNE
    if (mask == '0) q = q;
`endif
    max_v = (one << (out_w - 1)) - one;
    min_v = -max_v - one;
    if (q > max_v) begin
      res.p   = max_v;
      res.sat = 1'b1;
    end else if (q < min_v) begin
      res.p   = min_v;
      res.sat = 1'b1;
    end else begin
      res.p   = q;
      res.sat = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/opti_booth_row.sv
// One radix-4 Booth row: recode a 3-bit window of the multiplicand into a
// digit in {0,+1,+2,-1,-2} and form digit * sext(b) << SH at full product width.
module opti_booth_row
  import opti_mult_pkg::*;
#(
  parameter int B_W = 16,
  parameter int P_W = 32,
  parameter int SH  = 0
) (
  input  logic [2:0]     trip,
  input  logic [B_W-1:0] b,
  output logic [P_W-1:0] pp
);

  logic [2:0]     digit;
  logic [P_W-1:0] bx;
  logic [P_W-1:0] mag;

  // Recode window, then select the signed multiple of b and align it
  always_comb begin
    digit = B_ZERO;
    case (trip)
      3'b001, 3'b010: digit = B_P1;
      3'b011:         digit = B_P2;
      3'b100:         digit = B_M2;
      3'b101, 3'b110: digit = B_M1;
      default:        digit = B_ZERO;
    endcase
    bx  = P_W'(signed'(b));
    mag = '0;
    case (digit)
      B_P1:    mag = bx;
      B_P2:    mag = bx << 1;
      B_M1:    mag = -bx;
      B_M2:    mag = -(bx << 1);
      default: mag = '0;
    endcase
    pp = mag << SH;
  end

endmodule

// File: rtl/opti_booth_mult_p.sv
// Pipelined radix-4 Booth signed multiplier with round/saturate output.
// Stage 0 registers a/b, stages 1..N add one Booth row each into an exact
// (A_W+B_W)-bit accumulator, stage N+1 rounds and clips. Latency N+2.
// Build option OPTI_MULT_RNE_EN selects round-half-even on exact ties
// (handled inside opti_mult_pkg::sat_round).
//
// Handshake: a beat moves in when in_valid & in_ready and out when
// out_valid & out_ready. stall = out_valid & ~out_ready freezes every stage
// (single global enable), so p/sat hold while stalled and bubbles are kept.
// in_ready is low during reset and for the first cycle after release.
module opti_booth_mult_p
  import opti_mult_pkg::*;
#(
  parameter int A_W      = 16,
  parameter int B_W      = 16,
  parameter int A_FRAC   = 14,
  parameter int B_FRAC   = 14,
  parameter int OUT_W    = 16,
  parameter int OUT_FRAC = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] p,
  output logic             sat
);

  localparam int N     = booth_rows(A_W);
  localparam int P_W   = A_W + B_W;
  localparam int SHIFT = A_FRAC + B_FRAC - OUT_FRAC;

  if ((A_W % 2) != 0 || A_W < 4) begin : g_bad_a_w
    $error("opti_booth_mult_p: A_W must be even and >= 4");
  end
  if (SHIFT < 1) begin : g_bad_shift
    $error("opti_booth_mult_p: A_FRAC+B_FRAC-OUT_FRAC must be >= 1");
  end
  if (P_W > MAX_W - 2) begin : g_bad_p_w
    $error("opti_booth_mult_p: A_W+B_W too wide for sat_round");
  end

  logic                     rdy_q;
  logic                     stall;
  logic                     en;
  logic [N:0]               v_q;
  logic [A_W-1:0]           a_q [0:N-1];
  logic [B_W-1:0]           b_q [0:N-1];
  logic [N:1][P_W-1:0]      acc_q;
  logic [N-1:0][P_W-1:0]    pp;
  sat_res_t                 res;

  assign stall    = out_valid & ~out_ready;
  assign en       = ~stall;
  assign in_ready = rdy_q & ~stall;

  // Partial-product rows; row k reads the operands held in stage k
  for (genvar k = 0; k < N; k++) begin : g_row
    logic [2:0] trip;
    if (k == 0) begin : g_first
      assign trip = {a_q[0][1:0], 1'b0};
    end else begin : g_rest
      assign trip = a_q[k][2*k+1:2*k-1];
    end
    opti_booth_row #(
      .B_W (B_W),
      .P_W (P_W),
      .SH  (2*k)
    ) u_row (
      .trip (trip),
      .b    (b_q[k]),
      .pp   (pp[k])
    );
  end

  // Round and saturate the exact product leaving the last row stage
  always_comb begin
    res = sat_round(MAX_W'(signed'(acc_q[N])), SHIFT, OUT_W);
  end

  // Hold off input acceptance until the first clock after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_q <= 1'b0;
    else        rdy_q <= 1'b1;
  end

  // Pipeline registers, all advancing together under the global enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
      v_q       <= '0;
      acc_q     <= '0;
      out_valid <= 1'b0;
      p         <= '0;
      sat       <= 1'b0;
    end else if (en) begin
      v_q    <= {v_q[N-1:0], in_valid & in_ready};
      a_q[0] <= a;
      b_q[0] <= b;
      for (int k = 1; k < N; k++) begin
        a_q[k] <= a_q[k-1];
        b_q[k] <= b_q[k-1];
      end
      acc_q[1] <= pp[0];
      for (int k = 1; k < N; k++) begin
        acc_q[k+1] <= acc_q[k] + pp[k];
      end
      out_valid <= v_q[N];
      if (v_q[N]) begin
        p   <= res.p[OUT_W-1:0];
        sat <= res.sat;
      end
    end
  end

endmodule

// File: tb/tb_opti_booth_mult_p.sv
// Bench for opti_booth_mult_p at default parameters (Q2.14 in and out).
// Honours OPTI_MULT_RNE_EN for the tie-rounding expectations.
module tb_opti_booth_mult_p;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] p;
  logic        sat;

  int total = 0;
  int bad   = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  opti_booth_mult_p dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .sat       (sat)
  );

  // ---------------- golden model ----------------
  function automatic logic [16:0] model(input logic [15:0] ai, input logic [15:0] bi);
    longint full;
    longint r;
    longint q;
    full = longint'($signed(ai)) * longint'($signed(bi));
    r    = full + 64'sd8192;
    q    = r >>> 14;
`ifdef OPTI_MULT_RNE_EN
    if (((full & 64'sd16383) == 64'sd8192) && q[0]) q = q - 1;
`endif
    if (q > 64'sd32767)  return {1'b1, 16'h7FFF};
    if (q < -64'sd32768) return {1'b1, 16'h8000};
    return {1'b0, q[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [16:0] exp_q[$];
  bit          mon_en  = 1'b0;
  int          out_cnt = 0;
  bit          hold_v  = 1'b0;
  logic [16:0] hold_d;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      hold_v = 1'b0;
    end else if (mon_en) begin
      if (in_valid && in_ready) exp_q.push_back(model(a, b));
      if (hold_v) begin
        total++;
        if (out_valid !== 1'b1 || {sat, p} !== hold_d) begin
          bad++;
          $display("FAIL hold: got v=%0b %0h expected v=1 %0h", out_valid, {sat, p}, hold_d);
        end
      end
      if (out_valid && out_ready) begin
        total++;
        out_cnt++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_extra: got %0h expected no output", {sat, p});
        end else begin
          logic [16:0] e;
          e = exp_q.pop_front();
          if ({sat, p} !== e) begin
            bad++;
            $display("FAIL sb_data: got %0h expected %0h", {sat, p}, e);
          end
        end
      end
      hold_v = out_valid && !out_ready;
      hold_d = {sat, p};
    end else begin
      hold_v = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  // Single beat from idle at posedge+1; checks acceptance, latency, result
  task automatic run_vector(input logic [15:0] va, input logic [15:0] vb,
                            input logic [15:0] ep, input logic es, input string nm);
    int n;
    a = va; b = vb; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({nm, "_valid"}, 32'(out_valid), 32'd1);
    check({nm, "_latency"}, 32'(n), 32'd10);
    check({nm, "_p"}, 32'(p), 32'(ep));
    check({nm, "_sat"}, 32'(sat), 32'(es));
    @(posedge clk); #1;
    check({nm, "_drained"}, 32'(out_valid), 32'd0);
  endtask

  function automatic logic [15:0] pick_op();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'h0000;
      3:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] p;
    logic        s;
    string       nm;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int idx;
    int seen;
    int sent;
    int cyc;

    tbl[0]  = '{16'h2000, 16'h2000, 16'h1000, 1'b0, "half_sq"};
    tbl[1]  = '{16'h8000, 16'h8000, 16'h7FFF, 1'b1, "min_min"};
    tbl[2]  = '{16'h8000, 16'h7FFF, 16'h8000, 1'b1, "min_max"};
    tbl[3]  = '{16'h8000, 16'h2000, 16'hC000, 1'b0, "min_half"};
    tbl[4]  = '{16'hC000, 16'h7FFF, 16'h8001, 1'b0, "neg1_max"};
`ifdef OPTI_MULT_RNE_EN
    tbl[5]  = '{16'h0001, 16'h2000, 16'h0000, 1'b0, "tie_pos1"};
    tbl[8]  = '{16'hFFFD, 16'h2000, 16'hFFFE, 1'b0, "tie_neg3"};
`else
    tbl[5]  = '{16'h0001, 16'h2000, 16'h0001, 1'b0, "tie_pos1"};
    tbl[8]  = '{16'hFFFD, 16'h2000, 16'hFFFF, 1'b0, "tie_neg3"};
`endif
    tbl[6]  = '{16'h0003, 16'h2000, 16'h0002, 1'b0, "tie_pos3"};
    tbl[7]  = '{16'hFFFF, 16'h2000, 16'h0000, 1'b0, "tie_neg1"};
    tbl[9]  = '{16'h7FFF, 16'h4000, 16'h7FFF, 1'b0, "max_one"};
    tbl[10] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1, "max_max"};
    tbl[11] = '{16'h8000, 16'h4000, 16'h8000, 1'b0, "min_one"};
    tbl[12] = '{16'h8000, 16'h4001, 16'h8000, 1'b1, "min_over"};
    tbl[13] = '{16'h1234, 16'h0000, 16'h0000, 1'b0, "zero"};
    tbl[14] = '{16'hFFFF, 16'h0001, 16'h0000, 1'b0, "tiny_neg"};

    // Reset state
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_p", 32'(p), 32'd0);
    check("rst_sat", 32'(sat), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("rel_in_ready_high", 32'(in_ready), 32'd1);

    // Directed table
    for (int i = 0; i < 15; i++) begin
      run_vector(tbl[i].a, tbl[i].b, tbl[i].p, tbl[i].s, tbl[i].nm);
    end

    // Stream of 20 beats with out_ready low on cycles 12..16
    mon_en = 1'b1; out_cnt = 0; idx = 0;
    for (int c = 0; c < 40; c++) begin
      out_ready = !(c >= 12 && c <= 16);
      in_valid  = (idx < 20);
      a = 16'(idx * 4919 + 16'h8001);
      b = 16'(idx * 2731 ^ 16'hA5C3);
      @(negedge clk);
      check("stream_in_ready", 32'(in_ready), 32'(!(c >= 12 && c <= 16)));
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("stream_sent", 32'(idx), 32'd20);
    check("stream_out_cnt", 32'(out_cnt), 32'd20);
    check("stream_q_empty", 32'(exp_q.size()), 32'd0);

    // Reset with 6 beats in flight
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      a = 16'(c * 1111 + 16'h4000);
      b = 16'(16'h3000 - c * 777);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_rel_in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    check("no_stale_beat", 32'(seen), 32'd0);
    mon_en = 1'b0;
    run_vector(16'h2000, 16'h2000, 16'h1000, 1'b0, "post_rst");

    // Random operands with random in_valid / out_ready
    mon_en = 1'b1; out_cnt = 0; sent = 0; cyc = 0;
    while (sent < 10000 && cyc < 60000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = pick_op();
      b         = pick_op();
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    check("rand_sent", 32'(sent), 32'd10000);
    check("rand_out_cnt", 32'(out_cnt), 32'd10000);
    check("rand_q_empty", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
